// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder slice.
package serial_adder_pkg;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Combinational full adder built from two half adders and an OR of their carries.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Half adder cell: s = a ^ b, c = a & b.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB first, one bit per cycle, one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_c;
    logic               load;
    logic               step;
    logic               last;
    logic [WIDTH:0]     sum_ext;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // New sum bit enters at the MSB; shifting the extended vector keeps WIDTH=1 legal.
    assign sum_ext = {fa_s, sum};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last       = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (next_state != ST_IDLE);
            done <= (next_state == ST_DONE);
            if (load) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= cin;
                cnt   <= '0;
                sum   <= '0;
            end else if (step) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                carry <= fa_c;
                cnt   <= cnt + CNT_W'(1);
                sum   <= sum_ext[WIDTH:1];
                if (last) cout <= fa_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int         vectors = 0;
    int         errors  = 0;
    logic [8:0] exp_q[$];
    logic [1:0] exp1_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Present one start cycle and record the expected result; returns at the
    // falling edge after the accepting edge (cycle 1 of the operation).
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        exp_q.push_back(9'(ta) + 9'(tb) + 9'(tc));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; cyc is the cycle index after start was sampled.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 1;
        busy_cnt = 0;
        while (1) begin
            busy_cnt += int'(busy);
            if (done || cyc >= 40) break;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
        end
        vectors++;
        if ({busy1, done1, sum1, cout1} !== 4'd0) begin
            errors++;
            $display("FAIL reset_state_w1: got %b expected 0000", {busy1, done1, sum1, cout1});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int cyc, bc;
        logic [8:0] e;
        issue(8'h05, 8'h03, 1'b0);
        wait_done(cyc, bc);
        e = exp_q.pop_front();
        vectors++;
        if (cyc != 9 || !done) begin
            errors++;
            $display("FAIL basic_latency: done seen in cycle %0d (done=%b), expected cycle 9", cyc, done);
        end
        vectors++;
        if (bc != 9) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d expected 9", bc);
        end
        vectors++;
        if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL basic_result: got %h expected %h", {cout, sum}, e);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse_width: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_carry;
        int cyc, bc;
        logic [8:0] e;
        issue(8'hFF, 8'h01, 1'b0);
        wait_done(cyc, bc);
        e = exp_q.pop_front();
        vectors++;
        if (!done || {cout, sum} !== 9'h100) begin
            errors++;
            $display("FAIL carry_ff_01: got done=%b %h expected 100 (model %h)", done, {cout, sum}, e);
        end
        issue(8'hFF, 8'hFF, 1'b1);
        wait_done(cyc, bc);
        e = exp_q.pop_front();
        vectors++;
        if (!done || {cout, sum} !== 9'h1FF) begin
            errors++;
            $display("FAIL carry_ff_ff_1: got done=%b %h expected 1ff (model %h)", done, {cout, sum}, e);
        end
    endtask

    task automatic test_start_held;
        int cyc, bc;
        logic [8:0] e;
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h003);
        @(negedge clk);
        a = 8'h10; b = 8'h20;
        exp_q.push_back(9'h030);
        wait_done(cyc, bc);
        e = exp_q.pop_front();
        vectors++;
        if (!done || cyc != 9 || {cout, sum} !== e) begin
            errors++;
            $display("FAIL held_first: got done=%b cyc=%0d %h expected cyc 9 %h", done, cyc, {cout, sum}, e);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_idle_gap: got busy=%b expected 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_second_start: got busy=%b expected 1", busy);
        end
        wait_done(cyc, bc);
        e = exp_q.pop_front();
        vectors++;
        if (!done || cyc != 9 || {cout, sum} !== e) begin
            errors++;
            $display("FAIL held_second: got done=%b cyc=%0d %h expected cyc 9 %h", done, cyc, {cout, sum}, e);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc, bc;
        int seen;
        logic [8:0] e;
        issue(8'h12, 8'h34, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_async: got busy=%b done=%b sum=%h cout=%b expected all 0", busy, done, sum, cout);
        end
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            seen += int'(done) + int'(busy);
        end
        vectors++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d busy/done cycles expected 0", seen);
        end
        issue(8'h7A, 8'h0C, 1'b0);
        wait_done(cyc, bc);
        e = exp_q.pop_front();
        vectors++;
        if (!done || {cout, sum} !== 9'h086) begin
            errors++;
            $display("FAIL reset_fresh_op: got done=%b %h expected 086 (model %h)", done, {cout, sum}, e);
        end
    endtask

    task automatic test_random;
        int cyc, bc;
        logic [8:0] e;
        for (int i = 0; i < 1000; i++) begin
            issue(8'($urandom), 8'($urandom), 1'($urandom));
            wait_done(cyc, bc);
            e = exp_q.pop_front();
            vectors++;
            if (!done || cyc != 9 || {cout, sum} !== e) begin
                errors++;
                $display("FAIL random_%0d: got done=%b cyc=%0d %h expected %h", i, done, cyc, {cout, sum}, e);
            end
            for (int k = 0; k < int'($urandom_range(3, 0)); k++) begin
                @(negedge clk);
                vectors++;
                if ({cout, sum} !== e) begin
                    errors++;
                    $display("FAIL random_hold_%0d: got %h expected %h", i, {cout, sum}, e);
                end
            end
        end
    endtask

    task automatic test_width1;
        int cyc;
        logic [1:0] e;
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        exp1_q.push_back(2'(a1) + 2'(b1) + 2'(cin1));
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        e = exp1_q.pop_front();
        vectors++;
        if (!done1 || cyc != 2) begin
            errors++;
            $display("FAIL w1_latency: done seen in cycle %0d (done=%b) expected 2", cyc, done1);
        end
        vectors++;
        if ({cout1, sum1} !== e) begin
            errors++;
            $display("FAIL w1_result: got %b expected %b", {cout1, sum1}, e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_held();
        test_reset_mid_run();
        test_random();
        test_width1();
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
